// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect and decode handoff.
// master = fetch_queue side, slave = memory/datapath side.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    input  imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    output imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads imem one word at a time, buffers words for decode.
// Optional FETCH_QUEUE_STATS_EN adds pop / flush / stall counters as extra output ports.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding; requests while the queue has room
// WAIT     | accepted request outstanding; its response will be queued
// DISCARD  | outstanding response belongs to a flushed path; drop it
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [15:0]   stat_flushes,
  output logic [31:0]   stat_stall
`endif
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];

  logic imem_req;
  logic inst_valid;
  logic ack_fire;
  logic push;
  logic pop;

  // Gated by rst_n so nothing is offered while reset is held.
  assign imem_req   = rst_n && (state_q == S_IDLE) && (count_q < FULL);
  assign inst_valid = rst_n && (count_q != '0);
  assign ack_fire   = imem_req && bus.imem_ack;
  assign push       = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop        = inst_valid && bus.inst_ready && !bus.redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A request still in flight after this cycle must have its response dropped.
      if ((state_q == S_IDLE && ack_fire) || (state_q != S_IDLE && !bus.imem_rvalid))
        state_d = S_DISCARD;
      else
        state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ack_fire) begin
            state_d    = S_WAIT;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) state_d = S_IDLE;
        end
        S_DISCARD: begin
          if (bus.imem_rvalid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // fetch_pc has not moved since the ack, so the word's address is fetch_pc - 4.
      if (push) begin
        data_d[wr_ptr_q] = bus.imem_rdata;
        pc_d[wr_ptr_q]   = fetch_pc_q - 32'd4;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop)
        count_d = count_q + 1'b1;
      else if (pop && !push)
        count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: its contents are only visible behind inst_valid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = inst_valid ? data_q[rd_ptr_q] : '0;
  assign bus.inst_pc    = inst_valid ? pc_q[rd_ptr_q] : '0;
  assign bus.inst_pc4   = inst_valid ? (pc_q[rd_ptr_q] + 32'd4) : '0;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [15:0] flushes_q, flushes_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, pop};
    flushes_d = flushes_q + {15'd0, bus.redirect_valid};
    stall_d   = stall_q + {31'd0, (bus.inst_ready && !inst_valid)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushes_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushes_q <= flushes_d;
      stall_q   <= stall_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
  assign stat_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus directed literal checks
// for sequencing, back-pressure, redirects, PC wrap and mid-run reset.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if bus();

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
  logic [31:0] stat_stall;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushes (stat_flushes),
    .stat_stall   (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pop_pcs[$];
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_req_pc  = '0;
  logic        m_busy    = 1'b0;
  logic        m_drop    = 1'b0;
  logic [31:0] m_fetched = '0;
  logic [15:0] m_flushes = '0;
  logic [31:0] m_stall   = '0;

  function automatic logic exp_req();
    return rst_n && !m_busy && (m_q.size() < DEPTH);
  endfunction

  function automatic logic exp_valid();
    return rst_n && (m_q.size() > 0);
  endfunction

  always @(posedge clk) begin : model_upd
    logic ack, pop, inflight, stall;
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_pc      = RESET_PC;
      m_busy    = 1'b0;
      m_drop    = 1'b0;
      m_fetched = '0;
      m_flushes = '0;
      m_stall   = '0;
    end else begin
      ack   = exp_req() && bus.imem_ack;
      pop   = exp_valid() && bus.inst_ready;
      stall = bus.inst_ready && !exp_valid();
      if (stall) m_stall = m_stall + 1;
      if (bus.redirect_valid) begin
        inflight = (m_busy && !bus.imem_rvalid) || ack;
        m_q.delete();
        m_pc      = bus.redirect_pc & ~32'h3;
        m_busy    = inflight;
        m_drop    = inflight;
        m_flushes = m_flushes + 1;
      end else begin
        if (pop) begin
          m_pop_pcs.push_back(m_q[0].pc);
          void'(m_q.pop_front());
          m_fetched = m_fetched + 1;
        end
        if (m_busy && bus.imem_rvalid) begin
          if (!m_drop) begin
            e.data = bus.imem_rdata;
            e.pc   = m_req_pc;
            m_q.push_back(e);
          end
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
        if (ack) begin
          m_busy   = 1'b1;
          m_drop   = 1'b0;
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle compare, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req()});
    if (rst_n) chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_valid()});
    chk("inst_data", bus.inst_data, exp_valid() ? m_q[0].data : 32'd0);
    chk("inst_pc",   bus.inst_pc,   exp_valid() ? m_q[0].pc : 32'd0);
    chk("inst_pc4",  bus.inst_pc4,  exp_valid() ? (m_q[0].pc + 32'd4) : 32'd0);
  end

  // ---------------- stimulus + memory responder ----------------
  logic        s_rst_n    = 1'b0;
  logic        s_ready    = 1'b0;
  logic        s_redir    = 1'b0;
  logic [31:0] s_redir_pc = '0;
  logic        ack_en     = 1'b0;
  logic        hold_rsp   = 1'b0;
  logic        ovr_en     = 1'b0;
  logic [31:0] ovr_data   = '0;
  logic        pend       = 1'b0;
  logic [31:0] pend_data  = '0;
  int          ack_count  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic cycle();
    @(negedge clk);
    rst_n              = s_rst_n;
    bus.inst_ready     = s_ready;
    bus.redirect_valid = s_redir;
    bus.redirect_pc    = s_redir_pc;
    #1;
    if (pend && !hold_rsp) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ovr_en ? ovr_data : pend_data;
      pend            = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    bus.imem_ack = ack_en && bus.imem_req;
    if (bus.imem_ack) begin
      pend      = 1'b1;
      pend_data = mem_word(bus.imem_addr);
      ack_count++;
    end
  endtask

  task automatic do_reset();
    s_rst_n  = 1'b0;
    s_ready  = 1'b0;
    s_redir  = 1'b0;
    ack_en   = 1'b0;
    hold_rsp = 1'b0;
    ovr_en   = 1'b0;
    cycle();
    cycle();
    pend      = 1'b0;
    ack_count = 0;
    m_pop_pcs.delete();
    s_rst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // 1: sequential fetch, single-cycle memory, decode always ready
    do_reset();
    s_ready = 1'b1;
    ack_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      #2;
      case (k)
        0: begin
          chk("t1_req0", {31'd0, bus.imem_req}, 32'd1);
          chk("t1_addr0", bus.imem_addr, 32'h0);
        end
        2: begin
          chk("t1_pc_a", bus.inst_pc, 32'h0);
          chk("t1_pc4_a", bus.inst_pc4, 32'h4);
          chk("t1_data_a", bus.inst_data, 32'hFFFF_0000);
        end
        3: chk("t1_gap", {31'd0, bus.inst_valid}, 32'd0);
        4: begin
          chk("t1_pc_b", bus.inst_pc, 32'h4);
          chk("t1_pc4_b", bus.inst_pc4, 32'h8);
        end
        6: begin
          chk("t1_pc_c", bus.inst_pc, 32'h8);
          chk("t1_pc4_c", bus.inst_pc4, 32'hC);
        end
        default: ;
      endcase
    end
    chk("t1_model_pops", m_pop_pcs.size(), 32'd3);
    if (m_pop_pcs.size() == 3) chk("t1_model_pop2", m_pop_pcs[2], 32'h8);

    // 2: decode stalled, queue fills to DEPTH, one pop reopens fetch at 16
    do_reset();
    s_ready = 1'b0;
    ack_en  = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    #2;
    chk("t2_acks", ack_count, 32'd4);
    chk("t2_full_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t2_head_pc", bus.inst_pc, 32'h0);
    s_ready = 1'b1;
    cycle();
    #2;
    chk("t2_pop_valid", {31'd0, bus.inst_valid}, 32'd1);
    s_ready = 1'b0;
    cycle();
    #2;
    chk("t2_resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t2_resume_addr", bus.imem_addr, 32'h10);

    // 3: redirect while a request is outstanding; its late data must vanish
    do_reset();
    s_ready = 1'b1;
    ack_en  = 1'b1;
    cycle();
    hold_rsp   = 1'b1;
    s_redir    = 1'b1;
    s_redir_pc = 32'h40;
    cycle();
    #2;
    chk("t3_wait_req", {31'd0, bus.imem_req}, 32'd0);
    s_redir  = 1'b0;
    hold_rsp = 1'b0;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    cycle();
    #2;
    chk("t3_discard_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t3_discard_valid", {31'd0, bus.inst_valid}, 32'd0);
    ovr_en = 1'b0;
    cycle();
    #2;
    chk("t3_new_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t3_new_addr", bus.imem_addr, 32'h40);
    cycle();
    cycle();
    #2;
    chk("t3_first_pc", bus.inst_pc, 32'h40);
    chk("t3_first_data", bus.inst_data, 32'hFFBF_0040);

    // 4: redirect to an unaligned target in the same cycle as rvalid, queue non-empty
    do_reset();
    s_ready = 1'b0;
    ack_en  = 1'b1;
    cycle();
    cycle();
    cycle();
    s_redir    = 1'b1;
    s_redir_pc = 32'h103;
    cycle();
    #2;
    chk("t4_nonempty", {31'd0, bus.inst_valid}, 32'd1);
    s_redir = 1'b0;
    cycle();
    #2;
    chk("t4_flushed", {31'd0, bus.inst_valid}, 32'd0);
    chk("t4_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h100);
    cycle();
    cycle();
    #2;
    chk("t4_pc", bus.inst_pc, 32'h100);

    // 5: PC wrap at 2^32 and simultaneous push/pop with two entries queued
    do_reset();
    s_ready    = 1'b0;
    ack_en     = 1'b0;
    s_redir    = 1'b1;
    s_redir_pc = 32'hFFFF_FFF4;
    cycle();
    s_redir = 1'b0;
    ack_en  = 1'b1;
    cycle();
    #2;
    chk("t5_addr_f4", bus.imem_addr, 32'hFFFF_FFF4);
    cycle();
    cycle();
    cycle();
    cycle();
    #2;
    chk("t5_addr_fc", bus.imem_addr, 32'hFFFF_FFFC);
    s_ready = 1'b1;
    cycle();
    #2;
    chk("t5_pushpop_head", bus.inst_pc, 32'hFFFF_FFF4);
    ack_en = 1'b0;
    cycle();
    #2;
    chk("t5_order", bus.inst_pc, 32'hFFFF_FFF8);
    chk("t5_wrap_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5_wrap_addr", bus.imem_addr, 32'h0);
    cycle();
    #2;
    chk("t5_last_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("t5_last_pc4", bus.inst_pc4, 32'h0);
    cycle();
    #2;
    chk("t5_count2", {31'd0, bus.inst_valid}, 32'd0);
    s_ready = 1'b0;

    // 6: one-cycle reset while waiting; stray response afterwards is ignored
    do_reset();
    s_ready = 1'b1;
    ack_en  = 1'b1;
    cycle();
    s_rst_n  = 1'b0;
    hold_rsp = 1'b1;
    cycle();
    #2;
    chk("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t6_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_rst_data", bus.inst_data, 32'd0);
    chk("t6_rst_pc4", bus.inst_pc4, 32'd0);
    s_rst_n  = 1'b1;
    hold_rsp = 1'b0;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    cycle();
    #2;
    chk("t6_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t6_restart_addr", bus.imem_addr, RESET_PC);
    chk("t6_stray_valid", {31'd0, bus.inst_valid}, 32'd0);
    ovr_en = 1'b0;
    cycle();
    cycle();
    #2;
    chk("t6_first_pc", bus.inst_pc, 32'h0);
    chk("t6_first_data", bus.inst_data, 32'hFFFF_0000);

`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_flushes", {16'd0, stat_flushes}, {16'd0, m_flushes});
    chk("stat_stall", stat_stall, m_stall);
`endif

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
